// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer: client request FIFO replayed one access at a time onto the memory handshake
//
// Ports
//   clk_i, reset_ni                  clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_ready_o          client request handshake; req_ready_o=0 while the FIFO is full
//   req_op_i, req_addr_i, req_data_i request fields (op 1=write, 0=read)
//   rsp_valid_o/rsp_ready_i          response handshake, single held response register
//   rsp_op_o, rsp_data_o             op of the completed request, read data (0 for writes/timeouts)
//   rsp_status_o                     memory status, 2'b11 marks a timeout
//   mem_clr_o, mem_en_o              memory reset (clears its ready) and enable
//   mem_op_o, mem_addr_o, mem_datain_o  access command, held stable for the whole access
//   mem_dataout_i, mem_status_i, mem_ready_i  memory results
module mem_req_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_op_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [1:0]        rsp_status_o,
    output logic              mem_clr_o,
    output logic              mem_en_o,
    output logic              mem_op_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_datain_o,
    input  logic [DATA_W-1:0] mem_dataout_i,
    input  logic [1:0]        mem_status_i,
    input  logic              mem_ready_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int EW = 1 + ADDR_W + DATA_W;
    localparam logic [PW:0]   FULL = (PW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, CLR, ISSUE} state_t;

    state_t            state_q;
    logic [EW-1:0]     fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       fill_q, fill_d;
    logic [CW-1:0]     tmo_q;
    logic              rsp_valid_q, rsp_op_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [1:0]        rsp_status_q;
    logic              mem_clr_q, mem_en_q, mem_op_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_datain_q;
    logic              push, pop;
    logic [EW-1:0]     head;

    assign req_ready_o = fill_q != FULL;
    assign push        = req_valid_i && req_ready_o;
    // The head leaves the FIFO either to be issued or to be answered as a CLR timeout.
    assign pop         = state_q == CLR && (!mem_ready_i || tmo_q == TMAX);
    assign head        = fifo_q[rd_ptr_q];
    assign fill_d      = fill_q + (PW + 1)'(push) - (PW + 1)'(pop);

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_op_o     = rsp_op_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_status_o = rsp_status_q;
    assign mem_clr_o    = mem_clr_q;
    assign mem_en_o     = mem_en_q;
    assign mem_op_o     = mem_op_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_datain_o = mem_datain_q;

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= {req_op_i, req_addr_i, req_data_i};
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            fill_q   <= fill_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            tmo_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_op_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            mem_clr_q    <= 1'b1;
            mem_en_q     <= 1'b0;
            mem_op_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_datain_q <= '0;
        end else begin
            if (rsp_valid_q && rsp_ready_i) rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    mem_clr_q <= 1'b1;
                    mem_en_q  <= 1'b0;
                    // A pending response blocks the next access so responses never overtake.
                    if (fill_q != '0 && !rsp_valid_q) begin
                        tmo_q   <= '0;
                        state_q <= CLR;
                    end
                end
                CLR: begin
                    if (!mem_ready_i) begin
                        {mem_op_q, mem_addr_q, mem_datain_q} <= head;
                        mem_clr_q <= 1'b0;
                        mem_en_q  <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= ISSUE;
                    end else if (tmo_q == TMAX) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_op_q     <= head[EW-1];
                        rsp_data_q   <= '0;
                        rsp_status_q <= 2'b11;
                        tmo_q        <= '0;
                        state_q      <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ISSUE: begin
                    if (mem_ready_i || tmo_q == TMAX) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_op_q     <= mem_op_q;
                        rsp_data_q   <= (mem_ready_i && !mem_op_q) ? mem_dataout_i : '0;
                        rsp_status_q <= mem_ready_i ? mem_status_i : 2'b11;
                        mem_en_q     <= 1'b0;
                        mem_clr_q    <= 1'b1;
                        tmo_q        <= '0;
                        state_q      <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_en_clr: assert property (@(posedge clk_i) disable iff (!reset_ni) !(mem_en_o && mem_clr_o));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_ni) fill_q <= FULL);
endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb_mem_req_sequencer: scoreboard bench for mem_req_sequencer against a behavioural memory
module tb_mem_req_sequencer;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int T  = 64;

    typedef struct {
        logic          op;
        logic [DW-1:0] data;
        logic [1:0]    st;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid, req_ready, req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          rsp_valid, rsp_ready, rsp_op;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_status;
    logic          mem_clr, mem_en, mem_op, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_datain, mem_dataout;
    logic [1:0]    mem_status;

    logic [DW-1:0] mmem [256];
    logic [DW-1:0] ref_mem [256];
    logic          m_rdy = 1'b0;
    logic [1:0]    m_cnt = 2'd0;
    logic [DW-1:0] m_dout = '0;
    logic [1:0]    m_stat = 2'b00;
    int            mode;
    exp_t          sbq [$];
    int            checks = 0;
    int            errors = 0;
    int            en_cycles = 0;
    int            rsp_cnt = 0;

    always #5 clk = ~clk;

    mem_req_sequencer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT(T)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_op_o(rsp_op),
        .rsp_data_o(rsp_data), .rsp_status_o(rsp_status),
        .mem_clr_o(mem_clr), .mem_en_o(mem_en), .mem_op_o(mem_op),
        .mem_addr_o(mem_addr), .mem_datain_o(mem_datain),
        .mem_dataout_i(mem_dataout), .mem_status_i(mem_status), .mem_ready_i(mem_ready)
    );

    // Memory raises ready two cycles after enable; clr only clears ready, never the contents.
    always @(posedge clk) begin
        if (mem_clr) begin
            m_rdy <= 1'b0;
            m_cnt <= 2'd0;
        end else if (mem_en && !m_rdy) begin
            if (m_cnt == 2'd1) begin
                m_rdy  <= 1'b1;
                m_stat <= mem_op ? 2'b01 : 2'b10;
                if (mem_op) mmem[mem_addr] <= mem_datain;
                else m_dout <= mmem[mem_addr];
            end else begin
                m_cnt <= m_cnt + 2'd1;
            end
        end
    end

    assign mem_ready   = mode == 2 ? 1'b1 : mode == 1 ? 1'b0 : m_rdy;
    assign mem_dataout = m_dout;
    assign mem_status  = m_stat;

    task automatic monitor();
        exp_t          e;
        logic          prev_en = 1'b0;
        logic [AW+DW:0] prev_cmd = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_en = 1'b0;
            end else begin
                if (mem_en) begin
                    en_cycles++;
                    checks++;
                    if (mem_clr !== 1'b0) begin
                        errors++;
                        $display("FAIL en_with_clr: mem_clr=%b required 0 while mem_en=1", mem_clr);
                    end
                    if (prev_en) begin
                        checks++;
                        if ({mem_op, mem_addr, mem_datain} !== prev_cmd) begin
                            errors++;
                            $display("FAIL cmd_stable: got %h required %h", {mem_op, mem_addr, mem_datain}, prev_cmd);
                        end
                    end
                end
                prev_en  = mem_en;
                prev_cmd = {mem_op, mem_addr, mem_datain};
                if (rsp_valid && rsp_ready) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected: op=%b data=%h status=%b with empty scoreboard", rsp_op, rsp_data, rsp_status);
                    end else begin
                        e = sbq.pop_front();
                        rsp_cnt++;
                        if ({rsp_op, rsp_data, rsp_status} !== {e.op, e.data, e.st}) begin
                            errors++;
                            $display("FAIL rsp_%0d: got op=%b data=%h status=%b required op=%b data=%h status=%b",
                                     rsp_cnt, rsp_op, rsp_data, rsp_status, e.op, e.data, e.st);
                        end
                    end
                end
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge (or after budget cycles).
    task automatic send(input logic op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int budget, output bit acc);
        exp_t e;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            acc = req_ready;
            if (acc) begin
                e.op   = op;
                e.st   = mode == 0 ? (op ? 2'b01 : 2'b10) : 2'b11;
                e.data = (mode == 0 && !op) ? ref_mem[a] : '0;
                if (mode == 0 && op) ref_mem[a] = d;
                sbq.push_back(e);
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
        end
        checks++;
        if (mem_clr !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_ctl: mem_clr=%b mem_en=%b required 1 0", mem_clr, mem_en);
        end
        checks++;
        if ({mem_op, mem_addr, mem_datain} !== '0 || {rsp_op, rsp_data, rsp_status} !== '0) begin
            errors++;
            $display("FAIL reset_regs: mem=%h rsp=%h required 0 0", {mem_op, mem_addr, mem_datain}, {rsp_op, rsp_data, rsp_status});
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        bit acc;
        send(1'b1, 8'h08, 8'hF0, 10, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL write_accept: accepted=%b required 1", acc);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_latency: rsp_valid=%b required 0 one cycle after push", rsp_valid);
        end
        for (int i = 0; i < 100 && (sbq.size() != 0 || rsp_valid); i++) @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL write_drain: %0d pending required 0", sbq.size());
        end
    endtask

    task automatic test_read_order();
        bit acc;
        int base = rsp_cnt;
        send(1'b0, 8'h08, 8'h00, 10, acc);
        send(1'b1, 8'h09, 8'hF1, 10, acc);
        send(1'b0, 8'h09, 8'h00, 10, acc);
        for (int i = 0; i < 200 && (sbq.size() != 0 || rsp_valid); i++) @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (rsp_cnt - base != 3 || sbq.size() != 0) begin
            errors++;
            $display("FAIL order_count: got %0d responses required 3", rsp_cnt - base);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int n = 0;
        logic [DW+2:0] held;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(i[0] ? 1'b0 : 1'b1, 8'(8'h10 + (i & 6)), 8'(8'hA0 + i), 10, acc);
            if (acc) n++;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL b2b_accepted: got %0d required 5 (one in flight plus 4 queued)", n);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: req_ready=%b required 0", req_ready);
        end
        held = {rsp_op, rsp_data, rsp_status};
        repeat (5) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || {rsp_op, rsp_data, rsp_status} !== held) begin
            errors++;
            $display("FAIL b2b_hold: valid=%b rsp=%h required 1 %h", rsp_valid, {rsp_op, rsp_data, rsp_status}, held);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 300 && (sbq.size() != 0 || rsp_valid); i++) @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d pending required 0", sbq.size());
        end
    endtask

    task automatic test_issue_timeout();
        bit acc;
        mode      = 1;
        en_cycles = 0;
        send(1'b0, 8'h08, 8'h00, 10, acc);
        for (int i = 0; i < 4 * T && (sbq.size() != 0 || rsp_valid); i++) @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0 || en_cycles != T) begin
            errors++;
            $display("FAIL issue_timeout: pending=%0d en_cycles=%0d required 0 %0d", sbq.size(), en_cycles, T);
        end
        mode = 0;
        send(1'b0, 8'h09, 8'h00, 10, acc);
        for (int i = 0; i < 100 && (sbq.size() != 0 || rsp_valid); i++) @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL after_timeout: %0d pending required 0", sbq.size());
        end
    endtask

    task automatic test_clr_timeout();
        bit acc;
        send(1'b1, 8'h20, 8'h33, 10, acc);
        for (int i = 0; i < 100 && (sbq.size() != 0 || rsp_valid); i++) @(posedge clk);
        @(posedge clk);
        #1;
        mode      = 2;
        en_cycles = 0;
        send(1'b1, 8'h20, 8'h55, 10, acc);
        for (int i = 0; i < 4 * T && (sbq.size() != 0 || rsp_valid); i++) @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0 || en_cycles != 0) begin
            errors++;
            $display("FAIL clr_timeout: pending=%0d en_cycles=%0d required 0 0", sbq.size(), en_cycles);
        end
        mode = 0;
        send(1'b0, 8'h20, 8'h00, 10, acc);
        for (int i = 0; i < 100 && (sbq.size() != 0 || rsp_valid); i++) @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL clr_readback: %0d pending required 0", sbq.size());
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        bit seen = 1'b0;
        mode = 1;
        send(1'b0, 8'h08, 8'h00, 10, acc);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_en;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_issue: mem_en=%b required 1 within 20 cycles", mem_en);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_en !== 1'b0 || mem_clr !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: en=%b clr=%b rsp_valid=%b req_ready=%b required 0 1 0 1",
                     mem_en, mem_clr, rsp_valid, req_ready);
        end
        sbq.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mode    = 0;
        @(posedge clk);
        #1;
        send(1'b0, 8'h08, 8'h00, 10, acc);
        for (int i = 0; i < 100 && (sbq.size() != 0 || rsp_valid); i++) @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL post_reset: %0d pending required 0", sbq.size());
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        mode      = 0;
        fork
            monitor();
        join_none
        test_reset();
        test_write();
        test_read_order();
        test_back_to_back();
        test_issue_timeout();
        test_clr_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
